// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: NOP encoding, XLEN and the fetch FSM state encoding.
package rv32_pkg;

    localparam int unsigned RV32_XLEN = 32;
    localparam logic [31:0] RV32_NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_KILL = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/rv32im_fetch_buf.sv
// One-entry valid/ready holding register for a fetched {instr, pc} pair.
// Priority: flush > load > clear, so a redirect always empties the entry.
module rv32im_fetch_buf
    import rv32_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 clear,
    input  logic                 flush,
    input  logic [RV32_XLEN-1:0] wr_instr,
    input  logic [RV32_XLEN-1:0] wr_pc,
    output logic                 valid,
    output logic [RV32_XLEN-1:0] instr,
    output logic [RV32_XLEN-1:0] pc
);

    // Entry state: contents only change on load, so they stay stable while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            instr <= RV32_NOP;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= wr_instr;
            pc    <= wr_pc;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rv32im_fetch.sv
// Instruction fetch unit: drives the PC register's next value, runs the
// imem request/response handshake and feeds decode through a 1-entry buffer.
// Optional feature macro: RV32_FETCH_MISALIGN_EN (flag misaligned redirects
// instead of silently aligning the target).
module rv32im_fetch
    import rv32_pkg::*;
#(
    parameter logic [RV32_XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [RV32_XLEN-1:0] pc_i,
    output logic [RV32_XLEN-1:0] pc_next_o,
    input  logic                 redirect_i,
    input  logic [RV32_XLEN-1:0] redirect_pc_i,
    output logic                 imem_req_o,
    output logic [RV32_XLEN-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [RV32_XLEN-1:0] imem_rdata_i,
    output logic                 instr_valid_o,
    output logic [RV32_XLEN-1:0] instr_o,
    output logic [RV32_XLEN-1:0] instr_pc_o,
    input  logic                 instr_ready_i,
    output logic                 fetch_misalign_o
);

    fetch_state_e         state;
    logic [RV32_XLEN-1:0] req_pc;
    logic                 misalign_q;
    logic                 redir;
    logic                 gnt_eff;
    logic                 buf_load;
    logic                 buf_clear;
    logic [RV32_XLEN-1:0] redir_target;
    logic                 misalign_redir;

`ifdef RV32_FETCH_MISALIGN_EN
    assign redir_target   = redirect_pc_i;
    assign misalign_redir = (redirect_pc_i[1:0] != 2'b00);
`else
    assign redir_target   = redirect_pc_i & ~32'h0000_0003;
    assign misalign_redir = 1'b0;
    assign misalign_q     = 1'b0;
`endif

    // Request/handshake qualifiers; redirects are ignored while booting.
    always_comb begin
        redir      = redirect_i && (state != FETCH_BOOT);
        imem_req_o = (state == FETCH_REQ) && (!instr_valid_o || instr_ready_i) && !misalign_q;
        gnt_eff    = imem_req_o && imem_gnt_i;
        buf_load   = (state == FETCH_WAIT) && imem_rvalid_i;
        buf_clear  = instr_valid_o && instr_ready_i;
    end

    // Next PC selection: boot vector, then redirect, then sequential advance on grant.
    always_comb begin
        pc_next_o = pc_i;
        if (state == FETCH_BOOT) begin
            pc_next_o = RESET_VECTOR;
        end else if (redir) begin
            pc_next_o = redir_target;
        end else if (gnt_eff) begin
            pc_next_o = pc_i + 32'd4;
        end
    end

    assign imem_addr_o      = pc_i;
    assign fetch_misalign_o = misalign_q;

    // Fetch FSM; any redirect that leaves a request outstanding parks in KILL
    // so the stale response is swallowed instead of loading the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= FETCH_BOOT;
            req_pc <= '0;
`ifdef RV32_FETCH_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
`ifdef RV32_FETCH_MISALIGN_EN
            if (redir) begin
                misalign_q <= misalign_redir;
            end
`endif
            case (state)
                FETCH_BOOT: state <= FETCH_REQ;
                FETCH_REQ: begin
                    if (gnt_eff) begin
                        req_pc <= pc_i;
                        state  <= redir ? FETCH_KILL : FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid_i) begin
                        state <= FETCH_REQ;
                    end else if (redir) begin
                        state <= FETCH_KILL;
                    end
                end
                FETCH_KILL: begin
                    if (imem_rvalid_i) begin
                        state <= FETCH_REQ;
                    end
                end
                default: state <= FETCH_BOOT;
            endcase
        end
    end

    rv32im_fetch_buf u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (buf_load),
        .clear    (buf_clear),
        .flush    (redir),
        .wr_instr (imem_rdata_i),
        .wr_pc    (req_pc),
        .valid    (instr_valid_o),
        .instr    (instr_o),
        .pc       (instr_pc_o)
    );

endmodule

// File: tb/tb_rv32im_fetch.sv
// Directed bench for rv32im_fetch with a PC register and a single-cycle memory.
module tb_rv32im_fetch;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_misalign;

    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        inj_rvalid;
    logic        saw_108 = 1'b0;
    logic        found;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    rv32im_fetch #(.RESET_VECTOR(RV)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pc_i             (pc),
        .pc_next_o        (pc_next),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_gnt_i       (imem_gnt),
        .imem_rvalid_i    (imem_rvalid),
        .imem_rdata_i     (imem_rdata),
        .instr_valid_o    (instr_valid),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc),
        .instr_ready_i    (instr_ready),
        .fetch_misalign_o (fetch_misalign)
    );

    always #5 clk = ~clk;

    // External PC register, reset to the same vector the fetch unit boots from.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc <= RV;
        else          pc <= pc_next;
    end

    // Single-cycle memory: response exactly one cycle after a granted request.
    always @(posedge clk) begin
        mem_pend <= imem_req && imem_gnt;
        mem_addr <= imem_addr;
    end
    assign imem_rvalid = mem_pend | inj_rvalid;
    assign imem_rdata  = mem_word(mem_addr);

    always @(negedge clk) begin
        if (reset_n && instr_valid && instr_pc == 32'h108) saw_108 = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        inj_rvalid  = 1'b0;

        repeat (3) @(posedge clk);
        #2; settle;
        chk("rst_valid",    32'(instr_valid), 32'h0);
        chk("rst_instr",    instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_req",      32'(imem_req), 32'h0);
        chk("rst_pc_next",  pc_next, RV);
        chk("rst_addr",     imem_addr, RV);
        chk("rst_misalign", 32'(fetch_misalign), 32'h0);

        // Boot and sequential fetch at one instruction per two cycles.
        reset_n = 1'b1; settle;
        chk("boot_pc_next", pc_next, 32'h100);
        chk("boot_req",     32'(imem_req), 32'h0);
        step; settle;
        chk("c1_req",     32'(imem_req), 32'h1);
        chk("c1_addr",    imem_addr, 32'h100);
        chk("c1_pc_next", pc_next, 32'h104);
        step; settle;
        chk("c2_req",     32'(imem_req), 32'h0);
        chk("c2_pc_next", pc_next, 32'h104);
        chk("c2_valid",   32'(instr_valid), 32'h0);
        step; settle;
        chk("c3_valid",    32'(instr_valid), 32'h1);
        chk("c3_instr_pc", instr_pc, 32'h100);
        chk("c3_instr",    instr, mem_word(32'h100));
        chk("c3_req",      32'(imem_req), 32'h1);
        step; settle;
        chk("c4_valid", 32'(instr_valid), 32'h0);
        step; settle;
        chk("c5_valid",    32'(instr_valid), 32'h1);
        chk("c5_instr_pc", instr_pc, 32'h104);

        // Decode stall with 0x104 buffered.
        instr_ready = 1'b0; settle;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid",    32'(instr_valid), 32'h1);
            chk("stall_instr_pc", instr_pc, 32'h104);
            chk("stall_instr",    instr, mem_word(32'h104));
            chk("stall_req",      32'(imem_req), 32'h0);
            chk("stall_pc",       pc, 32'h108);
            step; settle;
        end

        // Redirect to 0x200 coinciding with the grant for 0x108.
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; settle;
        chk("rg_req",     32'(imem_req), 32'h1);
        chk("rg_pc_next", pc_next, 32'h200);
        step; redirect = 1'b0; settle;
        chk("kill_valid", 32'(instr_valid), 32'h0);
        chk("kill_pc",    pc, 32'h200);
        chk("kill_req",   32'(imem_req), 32'h0);
        step; settle;
        chk("r200_req",  32'(imem_req), 32'h1);
        chk("r200_addr", imem_addr, 32'h200);
        step; step; settle;
        chk("i200_valid", 32'(instr_valid), 32'h1);
        chk("i200_pc",    instr_pc, 32'h200);
        chk("i200_instr", instr, mem_word(32'h200));

        // PC wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle;
        step; redirect = 1'b0; settle;
        step; settle;
        chk("wrap_pc",      pc, 32'hFFFF_FFFC);
        chk("wrap_req",     32'(imem_req), 32'h1);
        chk("wrap_pc_next", pc_next, 32'h0);
        step; settle;
        chk("wrap_pc_after", pc, 32'h0);
        step; settle;
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        step; settle;
        chk("wait_req", 32'(imem_req), 32'h0);
        chk("wait_pc",  pc, 32'h4);

        // Reset pulse while WAIT, then a late response during BOOT.
        reset_n = 1'b0; settle;
        chk("mid_rst_valid",   32'(instr_valid), 32'h0);
        chk("mid_rst_pc_next", pc_next, RV);
        step; reset_n = 1'b1; inj_rvalid = 1'b1; settle;
        chk("late_boot_pc_next", pc_next, RV);
        chk("late_boot_req",     32'(imem_req), 32'h0);
        step; inj_rvalid = 1'b0; settle;
        chk("late_valid", 32'(instr_valid), 32'h0);
        chk("late_req",   32'(imem_req), 32'h1);
        chk("late_addr",  imem_addr, RV);
        step; step; settle;
        chk("restart_valid", 32'(instr_valid), 32'h1);
        chk("restart_pc",    instr_pc, RV);

        // Misaligned redirect target.
        redirect = 1'b1; redirect_pc = 32'h202; settle;
`ifdef RV32_FETCH_MISALIGN_EN
        chk("mis_pc_next", pc_next, 32'h202);
        step; redirect = 1'b0; settle;
        for (int i = 0; i < 3; i++) begin
            chk("mis_flag", 32'(fetch_misalign), 32'h1);
            chk("mis_req",  32'(imem_req), 32'h0);
            chk("mis_pc",   pc, 32'h202);
            step; settle;
        end
`else
        chk("mis_pc_next", pc_next, 32'h200);
        step; redirect = 1'b0; settle;
        chk("mis_flag", 32'(fetch_misalign), 32'h0);
        chk("mis_pc",   pc, 32'h200);
`endif

        // Aligned redirect to 0x300 resumes fetch there.
        redirect = 1'b1; redirect_pc = 32'h300; settle;
        chk("r300_pc_next", pc_next, 32'h300);
        step; redirect = 1'b0; settle;
        chk("r300_flag", 32'(fetch_misalign), 32'h0);
        chk("r300_pc",   pc, 32'h300);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (instr_valid) found = 1'b1;
            else begin step; settle; end
        end
        chk("r300_found",    32'(found), 32'h1);
        chk("r300_instr_pc", instr_pc, 32'h300);
        chk("r300_instr",    instr, mem_word(32'h300));

        chk("no_pc108", 32'(saw_108), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
